// File: rtl/accumulator_readout.sv
// -----------------------------------------------------------------------------
// accumulator_readout
//
// Drain side of the accumulation memory. Counts completed accumulation frames;
// once FRAMES_PER_READOUT frames have been summed it reads every bin in address
// order, streams each word to the consumer and clears the bin behind the read
// so the next window starts from an empty memory.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   i_frame_done        one-cycle pulse per finished accumulation pass
//   o_mem_rd_en/addr    RAM read port; data returns on i_mem_rd_data 1 cycle later
//   i_mem_rd_data       RAM read data
//   o_mem_clr_en/addr   RAM zero-write port, pulsed as each read returns
//   o_rd_valid/ready    output stream handshake
//   o_rd_data/index/last  head word, its bin address, last-bin marker
//   o_busy              high while draining (mirrors the FSM state)
//   o_frames_counted    frames seen in the current window
//   o_overrun           sticky: a frame ended while draining
//
// Handshake: a word transfers on a cycle where o_rd_valid & i_rd_ready. Once
// o_rd_valid is high it stays high, with data/index/last stable, until that
// transfer happens.
// -----------------------------------------------------------------------------
module accumulator_readout #(
   parameter int RAM_WIDTH          = 32,
   parameter int RAM_DEPTH          = 32,
   parameter int FRAMES_PER_READOUT = 8,
   localparam int AW = $clog2(RAM_DEPTH),
   localparam int FW = $clog2(FRAMES_PER_READOUT) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_frame_done,
   output logic                 o_mem_rd_en,
   output logic [AW-1:0]        o_mem_rd_addr,
   input  logic [RAM_WIDTH-1:0] i_mem_rd_data,
   output logic                 o_mem_clr_en,
   output logic [AW-1:0]        o_mem_clr_addr,
   output logic                 o_rd_valid,
   input  logic                 i_rd_ready,
   output logic [RAM_WIDTH-1:0] o_rd_data,
   output logic [AW-1:0]        o_rd_index,
   output logic                 o_rd_last,
   output logic                 o_busy,
   output logic [FW-1:0]        o_frames_counted,
   output logic                 o_overrun
);

   localparam logic [AW-1:0] LAST_IDX = AW'(RAM_DEPTH - 1);
   localparam logic [FW-1:0] FR_LAST  = FW'(FRAMES_PER_READOUT - 1);

   typedef enum logic {COUNT, DRAIN} state_t;

   state_t              state, state_nxt;
   logic [FW-1:0]       frames, frames_nxt;
   logic                overrun, overrun_nxt;

   logic [AW-1:0]       rd_addr;
   logic                all_issued;
   logic                inflight;
   logic [AW-1:0]       ret_addr;

   // 2-entry output buffer
   logic [RAM_WIDTH-1:0] data_q [2];
   logic [AW-1:0]        idx_q  [2];
   logic                 wr_ptr, rd_ptr;
   logic [1:0]           fifo_cnt;

   logic                 fifo_valid, head_last, pop, last_xfer, issue;
   logic [2:0]           occ_after;

   assign fifo_valid = (fifo_cnt != 2'd0);
   assign head_last  = (idx_q[rd_ptr] == LAST_IDX);
   assign pop        = fifo_valid & i_rd_ready;
   assign last_xfer  = pop & head_last;
   // Occupancy seen after this cycle's pop, counting the read still in flight.
   // Issuing only when this is <= 1 caps buffered+outstanding at 2.
   assign occ_after  = {1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, pop};

   always_comb begin
      state_nxt   = state;
      frames_nxt  = frames;
      overrun_nxt = overrun;
      issue       = 1'b0;
      case (state)
         COUNT: begin
            if (i_frame_done) begin
               if (frames == FR_LAST) begin
                  frames_nxt = '0;
                  state_nxt  = DRAIN;
               end else begin
                  frames_nxt = frames + 1'b1;
               end
            end
         end
         DRAIN: begin
            issue = !all_issued && (occ_after <= 3'd1);
            if (last_xfer) begin
               state_nxt = COUNT;
               // A frame ending with the last transfer opens the next window
               // (and with a one-frame window it starts the next drain).
               if (i_frame_done) begin
                  if (frames == FR_LAST) begin
                     state_nxt = DRAIN;
                  end else begin
                     frames_nxt = frames + 1'b1;
                  end
               end
            end else if (i_frame_done) begin
               overrun_nxt = 1'b1;
            end
         end
         default: state_nxt = COUNT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= COUNT;
         frames  <= '0;
         overrun <= 1'b0;
      end else begin
         state   <= state_nxt;
         frames  <= frames_nxt;
         overrun <= overrun_nxt;
      end
   end

   // Read pointer; it wraps to 0 after the last bin, all_issued stops issue.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_addr    <= '0;
         all_issued <= 1'b0;
         inflight   <= 1'b0;
         ret_addr   <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            rd_addr  <= rd_addr + 1'b1;
            ret_addr <= rd_addr;
            if (rd_addr == LAST_IDX) all_issued <= 1'b1;
         end
         if (last_xfer) all_issued <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q[0] <= '0;
         data_q[1] <= '0;
         idx_q[0]  <= '0;
         idx_q[1]  <= '0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         fifo_cnt  <= 2'd0;
      end else begin
         if (inflight) begin
            data_q[wr_ptr] <= i_mem_rd_data;
            idx_q[wr_ptr]  <= ret_addr;
            wr_ptr         <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
      end
   end

   assign o_mem_rd_en      = issue;
   assign o_mem_rd_addr    = rd_addr;
   assign o_mem_clr_en     = inflight;
   assign o_mem_clr_addr   = ret_addr;
   assign o_rd_valid       = fifo_valid;
   assign o_rd_data        = data_q[rd_ptr];
   assign o_rd_index       = idx_q[rd_ptr];
   assign o_rd_last        = fifo_valid & head_last;
   assign o_busy           = (state == DRAIN);
   assign o_frames_counted = frames;
   assign o_overrun        = overrun;

endmodule
